// File: rtl/rv_decode_execute_unit.sv
// rv_decode_execute_unit
//   RV32I decode, control generation, D/E pipeline register and ALU for the
//   in-order 5-stage core. Decode outputs are combinational from instr; the
//   D/E register latches the instruction fields, pc, RF read data and control
//   every cycle; the ALU result is combinational from the D/E register.
//
// Optional feature macro: ALU_MUL_EN (R-type funct7=0000001 -> MUL / MULHU).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr, pc       instruction word and its pc
//   rs1_data        RF read data for rs1
//   rs2_data        RF read data for rs2
//   stall           latch control bits as 0 (bubble)
//   rs1, rs2, rd    decode fields (combinational)
//   imm_sel         decode-stage immediate select (combinational)
//   id_reg_write    decode-stage reg_write (combinational)
//   ex_*            D/E-stage outputs; ex_zero == 1 means branch taken
module rv_decode_execute_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            stall,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [3:0]      imm_sel,
    output logic            id_reg_write,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [XLEN-1:0] ex_alu_result,
    output logic            ex_zero,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [12:0]     ex_b_imm
);

    typedef enum logic [6:0] {
        OPC_R      = 7'b0110011,
        OPC_I      = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111
    } opcode_e;

    typedef struct packed {
        logic       rw;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       br;
        logic       j;
        logic [3:0] imm_sel;
    } ctl_t;

    function automatic ctl_t decode(input logic [6:0] f7, input logic [2:0] f3,
                                    input logic [6:0] opc);
        ctl_t c;
        c = '0;
        case (opc)
            OPC_R: begin
                if (f7 == 7'b0000000 || f7 == 7'b0100000) c.rw = 1'b1;
`ifdef ALU_MUL_EN
                if (f7 == 7'b0000001) c.rw = 1'b1;
`endif
            end
            OPC_I: begin
                c.rw      = 1'b1;
                c.imm_sel = (f3 == 3'b001 || f3 == 3'b101) ? 4'd2 : 4'd1;
            end
            OPC_LOAD: begin
                c.rw = 1'b1; c.mr = 1'b1; c.m2r = 1'b1; c.imm_sel = 4'd1;
            end
            OPC_STORE: begin
                c.mw = 1'b1; c.imm_sel = 4'd3;
            end
            OPC_BRANCH:        c.br = 1'b1;
            OPC_JAL, OPC_JALR: begin
                c.rw = 1'b1; c.j = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [XLEN-1:0] alu_op(input logic [2:0] f3,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                               input logic sub, input logic arith);
        logic [XLEN-1:0] r;
        logic [4:0]      sh;
        sh = b[4:0];
        r  = '0;
        case (f3)
            3'b000: r = sub ? a - b : a + b;
            3'b001: r = a << sh;
            3'b010: r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011: r = {{(XLEN-1){1'b0}}, a < b};
            3'b100: r = a ^ b;
            3'b101: begin
                if (arith) r = $signed(a) >>> sh;
                else       r = a >> sh;
            end
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // ---------------- decode stage ----------------
    ctl_t w_id;
    assign w_id         = decode(instr[31:25], instr[14:12], instr[6:0]);
    assign rs1          = instr[19:15];
    assign rs2          = instr[24:20];
    assign rd           = instr[11:7];
    assign imm_sel      = w_id.imm_sel;
    assign id_reg_write = w_id.rw;

    // ---------------- D/E register ----------------
    // The rs1 field is not needed past decode, so only instr[31:20] and
    // instr[14:0] are kept. imm_sel and the ALU-enable (decode rw) are kept
    // unaffected by stall so the result is still formed during a bubble.
    logic [11:0]     r_hi;
    logic [14:0]     r_lo;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [5:0]      r_ctl;
    logic [3:0]      r_sel;
    logic            r_alu_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_pc     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ctl    <= '0;
            r_sel    <= '0;
            r_alu_ok <= 1'b0;
        end else begin
            r_hi     <= instr[31:20];
            r_lo     <= instr[14:0];
            r_pc     <= pc;
            r_a      <= rs1_data;
            r_b      <= rs2_data;
            r_ctl    <= stall ? 6'b0 : {w_id.rw, w_id.mr, w_id.mw, w_id.m2r, w_id.br, w_id.j};
            r_sel    <= w_id.imm_sel;
            r_alu_ok <= w_id.rw;
        end
    end

    assign {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_jump} = r_ctl;
    assign ex_rd       = r_lo[11:7];
    assign ex_rs2_data = r_b;
    assign ex_b_imm    = {r_hi[11], r_lo[7], r_hi[10:5], r_lo[11:8], 1'b0};

    // ---------------- execute stage ----------------
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [11:0]     w_s_imm;
    logic [XLEN-1:0] w_op2;
    logic [XLEN-1:0] w_res;
    logic            w_taken;

    assign w_opc   = r_lo[6:0];
    assign w_f3    = r_lo[14:12];
    assign w_f7    = r_hi[11:5];
    assign w_s_imm = {r_hi[11:5], r_lo[11:7]};

    always_comb begin
        w_op2 = '0;
        case (r_sel)
            4'd0: w_op2 = r_b;
            4'd1: w_op2 = {{(XLEN-12){r_hi[11]}}, r_hi};
            4'd2: w_op2 = {{(XLEN-12){1'b0}}, r_hi};
            4'd3: w_op2 = {{(XLEN-12){w_s_imm[11]}}, w_s_imm};
            default: w_op2 = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*XLEN-1:0] w_prod;
    assign w_prod = {{XLEN{1'b0}}, r_a} * {{XLEN{1'b0}}, w_op2};
`endif

    always_comb begin
        w_res   = '0;
        w_taken = 1'b0;
        case (w_opc)
            OPC_R, OPC_I: begin
                // r_alu_ok is low for R-type with an unsupported funct7
                if (r_alu_ok)
                    w_res = alu_op(w_f3, r_a, w_op2, (w_opc == OPC_R) && w_f7[5], w_f7[5]);
`ifdef ALU_MUL_EN
                if (r_alu_ok && w_opc == OPC_R && w_f7 == 7'b0000001) begin
                    case (w_f3)
                        3'b000:  w_res = w_prod[XLEN-1:0];
                        3'b011:  w_res = w_prod[2*XLEN-1:XLEN];
                        default: w_res = '0;
                    endcase
                end
`endif
            end
            OPC_LOAD, OPC_STORE: w_res = r_a + w_op2;
            OPC_BRANCH: begin
                case (w_f3)
                    3'b000:  w_taken = (r_a == r_b);
                    3'b001:  w_taken = (r_a != r_b);
                    3'b100:  w_taken = ($signed(r_a) <  $signed(r_b));
                    3'b101:  w_taken = ($signed(r_a) >= $signed(r_b));
                    3'b110:  w_taken = (r_a <  r_b);
                    3'b111:  w_taken = (r_a >= r_b);
                    default: w_taken = 1'b0;
                endcase
                // inverted so that ex_zero flags a taken branch
                w_res = {{(XLEN-1){1'b0}}, ~w_taken};
            end
            OPC_JAL, OPC_JALR: w_res = r_pc + XLEN'(PC_STEP);
            default: w_res = '0;
        endcase
    end

    assign ex_alu_result = w_res;
    assign ex_zero       = (w_res == '0);

endmodule

// File: tb/tb_rv_decode_execute_unit.sv
// Testbench for rv_decode_execute_unit: directed and random instructions,
// expected D/E outputs pushed to a scoreboard queue at issue time and
// compared by an independent monitor one clock later.
module tb_rv_decode_execute_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic        stall;
    logic [4:0]  rs1, rs2, rd, ex_rd;
    logic [3:0]  imm_sel;
    logic        id_reg_write;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_jump;
    logic [31:0] ex_alu_result, ex_rs2_data;
    logic        ex_zero;
    logic [12:0] ex_b_imm;

    rv_decode_execute_unit #(.XLEN(32), .PC_STEP(1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm_sel(imm_sel), .id_reg_write(id_reg_write),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_result(ex_alu_result),
        .ex_zero(ex_zero), .ex_rs2_data(ex_rs2_data), .ex_b_imm(ex_b_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [5:0]  ctl;   // {rw,mr,mw,m2r,br,j}
        logic [31:0] res;
        logic        zero;
        logic [31:0] rs2d;
        logic [12:0] bimm;
        bit          chk_res;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, input bit sub, input bit arith);
        logic [31:0] ones = '1;
        int unsigned sh = int'(b[4:0]);
        case (f3)
            3'd0: return sub ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return arith ? ((a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0)) : (a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit r_ok(input logic [6:0] f7);
`ifdef ALU_MUL_EN
        return f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01;
`else
        return f7 == 7'h00 || f7 == 7'h20;
`endif
    endfunction

    // expected {reg_write, imm_sel} for the decode stage
    function automatic logic [4:0] id_model(input logic [31:0] ins);
        logic [2:0] f3 = ins[14:12];
        case (ins[6:0])
            7'h33:        return {r_ok(ins[31:25]), 4'd0};
            7'h13:        return {1'b1, (f3 == 3'd1 || f3 == 3'd5) ? 4'd2 : 4'd1};
            7'h03:        return {1'b1, 4'd1};
            7'h23:        return {1'b0, 4'd3};
            7'h6F, 7'h67: return {1'b1, 4'd0};
            default:      return 5'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic stl, input logic rs);
        exp_t        e;
        logic [6:0]  f7 = ins[31:25];
        logic [2:0]  f3 = ins[14:12];
        logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        logic [31:0] res = 32'd0;
        logic [5:0]  ctl = 6'd0;
        logic [63:0] prod = 64'(a) * 64'(b);
        bit          taken = 0;
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00 || f7 == 7'h20) begin
                    ctl = 6'b100000;
                    res = ref_alu(f3, a, b, f7 == 7'h20, f7 == 7'h20);
                end
`ifdef ALU_MUL_EN
                else if (f7 == 7'h01) begin
                    ctl = 6'b100000;
                    res = (f3 == 3'd0) ? prod[31:0] : (f3 == 3'd3) ? prod[63:32] : 32'd0;
                end
`endif
            end
            7'h13: begin
                ctl = 6'b100000;
                res = ref_alu(f3, a, (f3 == 3'd1 || f3 == 3'd5) ? {20'd0, ins[31:20]} : ii, 0, ins[30]);
            end
            7'h03: begin ctl = 6'b110100; res = a + ii; end
            7'h23: begin ctl = 6'b001000; res = a + si; end
            7'h63: begin
                ctl = 6'b000010;
                case (f3)
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) < $signed(b));
                    3'd5: taken = ($signed(a) >= $signed(b));
                    3'd6: taken = (a < b);
                    3'd7: taken = (a >= b);
                    default: taken = 0;
                endcase
                res = taken ? 32'd0 : 32'd1;
            end
            7'h6F, 7'h67: begin ctl = 6'b100001; res = p + 32'd1; end
            default: ;
        endcase
        if (stl) ctl = 6'd0;
        e.rd = ins[11:7]; e.rs2d = b; e.bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.chk_res = !stl;
        if (rs) begin
            ctl = 6'd0; res = 32'd0; e.rd = 5'd0; e.rs2d = 32'd0; e.bimm = 13'd0; e.chk_res = 1;
        end
        e.ctl = ctl; e.res = res; e.zero = (res == 32'd0);
        return e;
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic stl, input logic rs);
        @(negedge clk);
        instr = ins; pc = p; rs1_data = a; rs2_data = b; stall = stl; rst = rs;
        sb.push_back(model(ins, p, a, b, stl, rs));
        #1;
        chk("decode", {12'd0, rs1, rs2, rd, id_reg_write, imm_sel},
            {12'd0, ins[19:15], ins[24:20], ins[11:7], id_model(ins)});
    endtask

    // monitor: one D/E result appears after every posedge following an issue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ex_ctl", {26'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                               ex_branch, ex_jump}, {26'd0, e.ctl});
                chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
                chk("ex_rs2_data", ex_rs2_data, e.rs2d);
                chk("ex_b_imm", {19'd0, ex_b_imm}, {19'd0, e.bimm});
                if (e.chk_res) begin
                    chk("ex_alu_result", ex_alu_result, e.res);
                    chk("ex_zero", {31'd0, ex_zero}, {31'd0, e.zero});
                end
            end
        end
    end

    function automatic logic [31:0] gen_instr();
        logic [4:0]  r_d = 5'($urandom), r_1 = 5'($urandom), r_2 = 5'($urandom);
        logic [2:0]  f3 = 3'($urandom);
        logic [6:0]  f7 = 7'($urandom);
        logic [6:0]  op;
        case ($urandom_range(0, 9))
            0: return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r_2, r_1, f3, r_d, 7'h33};
            1: return {7'h01, r_2, r_1, ($urandom_range(0, 1) == 1) ? 3'd0 : f3, r_d, 7'h33};
            2: begin
                while (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01) f7 = 7'($urandom);
                return {f7, r_2, r_1, f3, r_d, 7'h33};
            end
            3: return {f7, r_2, r_1, f3, r_d, 7'h13};
            4: return {f7, r_2, r_1, 3'd2, r_d, 7'h03};
            5: return {f7, r_2, r_1, 3'd2, r_d, 7'h23};
            6: return {f7, r_2, r_1, f3, r_d, 7'h63};
            7: return {f7, r_2, r_1, f3, r_d, 7'h6F};
            8: return {f7, r_2, r_1, 3'd0, r_d, 7'h67};
            default: begin
                op = 7'($urandom);
                while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 ||
                       op == 7'h63 || op == 7'h6F || op == 7'h67) op = 7'($urandom);
                return {f7, r_2, r_1, f3, r_d, op};
            end
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0; stall = 1'b0; rst = 1'b1;
        // reset state
        apply(32'h002081B3, 32'h10, 32'd5, 32'd7, 1'b0, 1'b1);
        // directed vectors
        apply(32'h002081B3, 32'h14, 32'd5, 32'd7, 1'b0, 1'b0);           // ADD x3,x1,x2
        apply(32'h40208133, 32'h18, 32'd5, 32'd7, 1'b0, 1'b0);           // SUB
        apply(32'hFFF00093, 32'h1C, 32'd0, 32'd3, 1'b0, 1'b0);           // ADDI -1
        apply(32'h4040D093, 32'h20, 32'h80000000, 32'd0, 1'b0, 1'b0);    // SRAI 4
        apply(32'h00208463, 32'h24, 32'd9, 32'd9, 1'b0, 1'b0);           // BEQ taken
        apply(32'h00209463, 32'h28, 32'd9, 32'd9, 1'b0, 1'b0);           // BNE not taken
        apply(32'h0020A223, 32'h2C, 32'h100, 32'hAB, 1'b0, 1'b0);        // SW x2,4(x1)
        apply(32'h0040A103, 32'h30, 32'h200, 32'd1, 1'b0, 1'b0);         // LW
        apply(32'h008000EF, 32'h34, 32'd0, 32'd0, 1'b0, 1'b0);           // JAL
        apply(32'h000080E7, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0);     // JALR, pc wrap
        apply(32'h022081B3, 32'h38, 32'd6, 32'd7, 1'b0, 1'b0);           // MUL
        apply(32'h0220B1B3, 32'h3C, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0); // MULHU
        apply(32'h042081B3, 32'h40, 32'd6, 32'd7, 1'b0, 1'b0);           // bad funct7
        apply(32'h002081B3, 32'h44, 32'd5, 32'd7, 1'b1, 1'b0);           // stalled ADD
        apply(32'h0020A223, 32'h48, 32'h100, 32'hAB, 1'b1, 1'b1);        // rst wins over stall
        apply(32'h0000007F, 32'h4C, 32'd1, 32'd2, 1'b0, 1'b0);           // unknown opcode
        // random stream
        for (int unsigned i = 0; i < 400; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a = 32'($urandom_range(0, 40));
                b = 32'($urandom_range(0, 40));
            end
            apply(gen_instr(), $urandom, a, b, $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
